// File: rtl/xlr8_hdmi_regbank_pkg.sv
// xlr8_hdmi_regbank_pkg: shared state encoding and control/status bit positions for the HDMI register bank
package xlr8_hdmi_regbank_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} regbank_state_t;
  localparam int CTRL_ARM    = 0;
  localparam int CTRL_CANCEL = 1;
  localparam int CTRL_FORCE  = 2;
  localparam int ST_PENDING  = 0;
  localparam int ST_DONE     = 1;
endpackage

// File: rtl/xlr8_regbank_cell.sv
// xlr8_regbank_cell: one shadow/active register pair; ports clk, rst (async high), we loads shadow from d, commit copies shadow into active
module xlr8_regbank_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             commit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (we) shadow <= d;
      if (commit) active <= shadow;
    end
endmodule

// File: rtl/xlr8_hdmi_regbank.sv
// xlr8_hdmi_regbank: double-buffered AVR register bank; ports clk/rst/clken, AVR DM bus (dbus_in, dbus_out, io_out_en, ramadr, ramre, ramwe, dm_sel), frame_start in, active_regs/commit_pulse/pending out
module xlr8_hdmi_regbank
  import xlr8_hdmi_regbank_pkg::*;
#(
  parameter int NUM_REGS    = 6,
  parameter int WIDTH       = 8,
  parameter int BASE_ADDR   = 0,
  parameter int CTRL_ADDR   = 0,
  parameter int STATUS_ADDR = 0,
  parameter int FCNT_ADDR   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clken,
  input  logic [7:0]                dbus_in,
  output logic [7:0]                dbus_out,
  output logic                      io_out_en,
  input  logic [7:0]                ramadr,
  input  logic                      ramre,
  input  logic                      ramwe,
  input  logic                      dm_sel,
  input  logic                      frame_start,
  output logic [NUM_REGS*WIDTH-1:0] active_regs,
  output logic                      commit_pulse,
  output logic                      pending
);
  regbank_state_t state_q, state_d;
  logic ctrl_hit, status_hit, fcnt_hit, spec_hit, ctrl_wr, arm, cancel, force_c, commit, done_q;
  logic [7:0] fcnt_q, shadow_rd;
  logic [NUM_REGS-1:0] reg_hit;
  logic [WIDTH-1:0] shadow [NUM_REGS];
  // Aliased addresses resolve CTRL > STATUS > FCNT > shadow
  assign ctrl_hit   = dm_sel && ramadr == 8'(CTRL_ADDR);
  assign status_hit = dm_sel && ramadr == 8'(STATUS_ADDR) && !ctrl_hit;
  assign fcnt_hit   = dm_sel && ramadr == 8'(FCNT_ADDR) && !ctrl_hit && !status_hit;
  assign spec_hit   = ctrl_hit || status_hit || fcnt_hit;
  assign ctrl_wr    = clken && ramwe && ctrl_hit;
  assign arm        = ctrl_wr && dbus_in[CTRL_ARM];
  assign cancel     = ctrl_wr && dbus_in[CTRL_CANCEL];
  assign force_c    = ctrl_wr && dbus_in[CTRL_FORCE];
  assign commit     = state_q == COMMIT;
  assign pending    = state_q == ARMED;
  assign io_out_en  = ramre && (spec_hit || |reg_hit);
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      assign reg_hit[g] = dm_sel && ramadr == 8'(BASE_ADDR + g) && !spec_hit;
      xlr8_regbank_cell #(.WIDTH(WIDTH)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .we     (clken && ramwe && reg_hit[g]),
        .commit (commit),
        .d      (dbus_in[WIDTH-1:0]),
        .shadow (shadow[g]),
        .active (active_regs[g*WIDTH +: WIDTH])
      );
    end
  endgenerate
  // FORCE beats everything; COMMIT lasts exactly one cycle whatever the bus does
  always_comb
    state_d = commit ? IDLE :
              force_c ? COMMIT :
              pending ? (frame_start ? COMMIT : cancel ? IDLE : ARMED) :
              arm ? ARMED : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      commit_pulse <= 1'b0;
      done_q       <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      commit_pulse <= commit;
      done_q       <= commit || (done_q && !(status_hit && ramre));
      fcnt_q       <= fcnt_q + 8'(frame_start);
    end
  always_comb begin
    shadow_rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_hit[i]) shadow_rd = 8'(shadow[i]);
    dbus_out = ctrl_hit ? 8'h00 :
               status_hit ? 8'((32'(done_q) << ST_DONE) | (32'(pending) << ST_PENDING)) :
               fcnt_hit ? fcnt_q : shadow_rd;
  end
endmodule

// File: tb/tb_xlr8_hdmi_regbank.sv
// tb_xlr8_hdmi_regbank: directed and random checks of the register bank against a cycle-level behavioural model
module tb_xlr8_hdmi_regbank;
  localparam int N = 6;
  localparam logic [7:0] BASE = 8'h10, CTRL = 8'h20, STAT = 8'h21, FCNT = 8'h22;
  logic clk = 0, rst = 1, clken = 0, ramre = 0, ramwe = 0, dm_sel = 0, frame_start = 0;
  logic [7:0] dbus_in = 0, ramadr = 0, dbus_out;
  logic io_out_en, commit_pulse, pending;
  logic [N*8-1:0] active_regs;
  logic [7:0] sh_m [N], ac_m [N], fc_m;
  bit armed, cn, pulse_m, done_m;
  int checks = 0, fails = 0;

  xlr8_hdmi_regbank #(.NUM_REGS(N), .WIDTH(8), .BASE_ADDR(int'(BASE)), .CTRL_ADDR(int'(CTRL)),
                      .STATUS_ADDR(int'(STAT)), .FCNT_ADDR(int'(FCNT))) dut (
    .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
    .frame_start(frame_start), .active_regs(active_regs), .commit_pulse(commit_pulse), .pending(pending));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*8-1:0] act_exp();
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = ac_m[i];
    return r;
  endfunction

  function automatic bit in_bank(logic [7:0] a);
    return a >= BASE && int'(a) < int'(BASE) + N;
  endfunction

  function automatic logic [7:0] rd_exp(logic [7:0] a, bit s);
    if (!s || a == CTRL) return 8'h00;
    if (a == STAT) return {6'b0, done_m, armed};
    if (a == FCNT) return fc_m;
    if (in_bank(a)) return sh_m[int'(a - BASE)];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin sh_m[i] = 0; ac_m[i] = 0; end
    fc_m = 0; armed = 0; cn = 0; pulse_m = 0; done_m = 0;
  endtask

  task automatic step(input logic [7:0] a, input bit we, input bit re, input logic [7:0] d,
                      input bit fs, input bit s, input bit en);
    bit oc, wr, f, c, ar;
    @(negedge clk);
    ramadr = a; ramwe = we; ramre = re; dbus_in = d; frame_start = fs; dm_sel = s; clken = en;
    #1;
    if (re) begin
      chk("read_data", dbus_out, rd_exp(a, s));
      chk("io_out_en", io_out_en, s && (a == CTRL || a == STAT || a == FCNT || in_bank(a)));
    end
    @(posedge clk);
    oc = cn;
    pulse_m = oc;
    if (oc) ac_m = sh_m;
    done_m = oc ? 1'b1 : (re && s && a == STAT) ? 1'b0 : done_m;
    wr = we && en && s;
    f = wr && a == CTRL && d[2];
    c = wr && a == CTRL && d[1];
    ar = wr && a == CTRL && d[0];
    cn = 0;
    if (!oc) begin
      if (f || (armed && fs)) begin cn = 1; armed = 0; end
      else if (armed && c) armed = 0;
      else if (!armed && ar) armed = 1;
    end
    if (wr && in_bank(a)) sh_m[int'(a - BASE)] = d;
    fc_m = fc_m + 8'(fs);
    #1;
    chk("active_regs", active_regs, act_exp());
    chk("pending", pending, armed);
    chk("commit_pulse", commit_pulse, pulse_m);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit fs);
    step(a, 1, 0, d, fs, 1, 1);
  endtask
  task automatic rd(input logic [7:0] a);
    step(a, 0, 1, 8'h00, 0, 1, 1);
  endtask
  task automatic idle(input int n, input bit fs);
    for (int i = 0; i < n; i++) step(8'h00, 0, 0, 8'h00, fs, 0, 1);
  endtask

  initial begin
    logic [7:0] a, d;
    int r;
    bit we, re, fs, s, en;
    model_reset();
    #12 rst = 0;
    for (int i = 0; i < N; i++) rd(BASE + 8'(i));
    rd(STAT);
    rd(FCNT);
    chk("reset_active", active_regs, '0);
    chk("reset_pending", pending, 1'b0);
    // forced commit: active follows one edge after the FORCE write
    wr(BASE + 8'd2, 8'hA5, 0);
    wr(CTRL, 8'h04, 0);
    chk("force_not_yet", active_regs[16 +: 8], 8'h00);
    idle(1, 0);
    chk("force_active", active_regs[16 +: 8], 8'hA5);
    chk("force_pulse", commit_pulse, 1'b1);
    idle(1, 0);
    rd(STAT);
    rd(STAT);
    // frame-synchronous commit
    wr(BASE, 8'h3C, 0);
    wr(CTRL, 8'h01, 0);
    idle(10, 0);
    chk("armed_hold", active_regs[0 +: 8], 8'h00);
    chk("armed_pending", pending, 1'b1);
    idle(1, 1);
    idle(1, 0);
    chk("frame_commit", active_regs[0 +: 8], 8'h3C);
    chk("frame_pending", pending, 1'b0);
    // ARM alongside frame_start waits for the next frame
    wr(BASE + 8'd1, 8'h77, 0);
    wr(CTRL, 8'h01, 1);
    idle(3, 0);
    chk("arm_fs_wait", active_regs[8 +: 8], 8'h00);
    idle(1, 1);
    idle(2, 0);
    chk("arm_fs_commit", active_regs[8 +: 8], 8'h77);
    // cancel drops the armed commit
    wr(BASE + 8'd3, 8'h5A, 0);
    wr(CTRL, 8'h01, 0);
    wr(CTRL, 8'h02, 0);
    idle(1, 1);
    idle(1, 0);
    chk("cancel_hold", active_regs[24 +: 8], 8'h00);
    rd(FCNT);
    rd(STAT);
    // counter wrap after 256 frames
    idle(256, 1);
    idle(1, 0);
    rd(FCNT);
    // async reset while armed
    wr(CTRL, 8'h01, 0);
    idle(1, 0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_pending", pending, 1'b0);
    chk("rst_active", active_regs, '0);
    model_reset();
    rst = 0;
    rd(BASE + 8'd2);
    rd(FCNT);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      a = r < N ? BASE + 8'(r) : r == 6 ? CTRL : r == 7 ? STAT : r == 8 ? FCNT : 8'h05;
      we = $urandom_range(0, 1) == 1;
      re = !we || $urandom_range(0, 3) == 0;
      d = 8'($urandom);
      fs = $urandom_range(0, 7) == 0;
      if (we && a == CTRL && d[1]) fs = 0;
      s = $urandom_range(0, 9) != 0;
      en = $urandom_range(0, 7) != 0;
      step(a, we, re, d, fs, s, en);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
